// File: rtl/pifo_enq_arbiter.sv
// Round-robin enqueue arbiter: per-port staging, one PIFO insert per cycle.
// Build option: define PIFO_ENQ_DROP_ON_FULL_EN to drop on pifo_full.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              grant enable (staging keeps accepting when low)
//   in_valid/ready  per-port request handshake
//   in_rank/meta    packed per-port rank and metadata
//   pifo_insert     insert strobe, with pifo_rank_in and pifo_meta_in
//   pifo_meta_in    {meta, source port index}
//   pifo_busy/full  PIFO backpressure
//   drop_count      saturating count of requests discarded on full
module pifo_enq_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int RANK_WIDTH = 10,
  parameter int META_WIDTH = 20,
  localparam int PORT_W =
    (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*RANK_WIDTH-1:0] in_rank,
  input  logic [NUM_PORTS*META_WIDTH-1:0] in_meta,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic                           pifo_insert,
  output logic [RANK_WIDTH-1:0]          pifo_rank_in,
  output logic [META_WIDTH+PORT_W-1:0]   pifo_meta_in,
  input  logic                           pifo_busy,
  input  logic                           pifo_full,
  output logic [15:0]                    drop_count
);

  logic [NUM_PORTS-1:0]  stage_valid;
  logic [RANK_WIDTH-1:0] stage_rank [NUM_PORTS];
  logic [META_WIDTH-1:0] stage_meta [NUM_PORTS];

  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    winner;
  logic [PORT_W-1:0]    next_ptr;
  logic                 found;
  logic                 can_issue;
  logic                 issue;
  logic                 drop;
  logic                 take;
  logic [NUM_PORTS-1:0] vacate;
  logic [NUM_PORTS-1:0] load;

  // First staged port scanning from rr_ptr with wrap.
  always_comb begin : pick
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && stage_valid[idx]) begin
        found  = 1'b1;
        winner = PORT_W'(idx);
      end
    end
  end

  assign next_ptr =
    (winner == PORT_W'(NUM_PORTS - 1)) ? '0
                                       : winner + PORT_W'(1);

  assign can_issue = en & ~pifo_busy & ~pifo_full;
  assign issue     = can_issue & found & ~rst;

`ifdef PIFO_ENQ_DROP_ON_FULL_EN
  // Full PIFO: the winner is discarded instead of stalling.
  assign drop = en & pifo_full & found & ~rst;
`else
  assign drop = 1'b0;
`endif

  assign take   = issue | drop;
  assign vacate = take ? (NUM_PORTS'(1) << winner) : '0;

  // A slot being emptied this cycle may be refilled on the same edge.
  assign in_ready = rst ? '0 : (~stage_valid | vacate);
  assign load     = in_valid & in_ready;

  assign pifo_insert  = issue;
  assign pifo_rank_in = issue ? stage_rank[winner] : '0;
  assign pifo_meta_in =
    issue ? {stage_meta[winner], winner} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      rr_ptr      <= '0;
    end else begin
      stage_valid <= (stage_valid & ~vacate) | load;
      if (take) rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (load[p]) begin
        stage_rank[p] <= in_rank[p*RANK_WIDTH +: RANK_WIDTH];
        stage_meta[p] <= in_meta[p*META_WIDTH +: META_WIDTH];
      end
    end
  end

`ifdef PIFO_ENQ_DROP_ON_FULL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule
